// File: rtl/evt_pkg.sv
// evt_pkg: shared state type and width helpers for the event-burst generator
package evt_pkg;
   typedef enum logic {EVT_IDLE, EVT_RUN} evt_gen_state_t;
   function automatic int period_w(input int max_period);
      return $clog2(max_period + 1);
   endfunction
   function automatic int count_w(input int max_count);
      return $clog2(max_count + 1);
   endfunction
endpackage

// File: rtl/evt_period_timer.sv
// evt_period_timer: phase counter that ticks once every `period` enabled cycles
module evt_period_timer #(
   parameter int PW = 16
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          clear,
   input  logic          enable,
   input  logic [PW-1:0] period,
   output logic          tick
);
   logic [PW-1:0] phase;
   assign tick = enable && (phase == period - PW'(1));
   // phase wraps to 0 on the tick so the next interval starts immediately
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) phase <= '0;
      else if (clear) phase <= '0;
      else if (enable) phase <= tick ? '0 : phase + PW'(1);
endmodule

// File: rtl/evt_burst_gen.sv
// evt_burst_gen: burst of evenly spaced one-cycle strobes; EVT_BURST_GEN_REPEAT_EN adds repeat_in
module evt_burst_gen
   import evt_pkg::*;
#(
   parameter int MAX_PERIOD = 65535,
   parameter int MAX_COUNT  = 255,
   localparam int PW = period_w(MAX_PERIOD),
   localparam int CW = count_w(MAX_COUNT)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          start_in,
   input  logic          stop_in,
`ifdef EVT_BURST_GEN_REPEAT_EN
   input  logic          repeat_in,
`endif
   input  logic [PW-1:0] period_in,
   input  logic [CW-1:0] count_in,
   output logic          evt_out,
   output logic          busy_out,
   output logic          done_out,
   output logic [CW-1:0] remaining_out
);
   evt_gen_state_t state, state_d;
   logic [PW-1:0] per_q, per_d;
   logic [CW-1:0] cnt_q, cnt_d, rem_d;
   logic evt_d, busy_d, done_d, tick, accept, last, rep;
`ifdef EVT_BURST_GEN_REPEAT_EN
   assign rep = repeat_in;
`else
   assign rep = 1'b0;
`endif
   assign accept = (state == EVT_IDLE) && start_in && (count_in != '0) && (period_in != '0);
   assign last = tick && (remaining_out == CW'(1));
   evt_period_timer #(.PW(PW)) u_timer (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (accept),
      .enable (state == EVT_RUN),
      .period (per_q),
      .tick   (tick)
   );
   // next-state and output decode; stop beats an event due on the same edge
   always_comb begin
      state_d = state;
      per_d   = per_q;
      cnt_d   = cnt_q;
      rem_d   = remaining_out;
      busy_d  = busy_out;
      evt_d   = 1'b0;
      done_d  = 1'b0;
      if (state == EVT_IDLE) begin
         if (accept) begin
            state_d = EVT_RUN;
            per_d   = period_in;
            cnt_d   = count_in;
            rem_d   = count_in;
            busy_d  = 1'b1;
         end else done_d = start_in;
      end else if (stop_in) begin
         state_d = EVT_IDLE;
         rem_d   = '0;
         busy_d  = 1'b0;
      end else if (tick) begin
         evt_d   = 1'b1;
         done_d  = last;
         rem_d   = (last && rep) ? cnt_q : remaining_out - CW'(1);
         state_d = (last && !rep) ? EVT_IDLE : EVT_RUN;
         busy_d  = !(last && !rep);
      end
   end
   // state and registered outputs
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         state         <= EVT_IDLE;
         per_q         <= '0;
         cnt_q         <= '0;
         remaining_out <= '0;
         evt_out       <= 1'b0;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
      end else begin
         state         <= state_d;
         per_q         <= per_d;
         cnt_q         <= cnt_d;
         remaining_out <= rem_d;
         evt_out       <= evt_d;
         busy_out      <= busy_d;
         done_out      <= done_d;
      end
endmodule

// File: tb/tb_evt_burst_gen.sv
// tb_evt_burst_gen: directed self-checking bench for evt_burst_gen
module tb_evt_burst_gen;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic start_in = 1'b0;
   logic stop_in = 1'b0;
   logic [15:0] period_in = '0;
   logic [7:0] count_in = '0;
   logic evt_out, busy_out, done_out;
   logic [7:0] remaining_out;
   int n_checks = 0;
   int n_fail = 0;
`ifdef EVT_BURST_GEN_REPEAT_EN
   logic repeat_in = 1'b0;
`endif

   evt_burst_gen dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .stop_in       (stop_in),
`ifdef EVT_BURST_GEN_REPEAT_EN
      .repeat_in     (repeat_in),
`endif
      .period_in     (period_in),
      .count_in      (count_in),
      .evt_out       (evt_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .remaining_out (remaining_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({evt_out, busy_out, done_out, remaining_out} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset: got evt=%b busy=%b done=%b rem=%0d, want all 0", evt_out, busy_out, done_out, remaining_out);
      end
      step();
      rst_in = 1'b0;
      step();
   endtask

   // period=3 count=4, with a busy-time start and changed inputs that must be ignored
   task automatic test_basic();
      logic e, d, b;
      logic [7:0] r;
      period_in = 16'd3; count_in = 8'd4; start_in = 1'b1;
      step();
      period_in = 16'd1; count_in = 8'd9;
      n_checks++;
      if (busy_out !== 1'b1 || remaining_out !== 8'd4 || evt_out !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_accept: got busy=%b rem=%0d evt=%b, want busy=1 rem=4 evt=0", busy_out, remaining_out, evt_out);
      end
      for (int s = 1; s <= 14; s++) begin
         if (s == 12) start_in = 1'b0;
         step();
         e = (s % 3 == 0) && s <= 12;
         d = (s == 12);
         b = (s < 12);
         r = (s >= 12) ? 8'd0 : 8'(4 - s / 3);
         n_checks++;
         if (evt_out !== e || done_out !== d || busy_out !== b || remaining_out !== r) begin
            n_fail++;
            $display("FAIL basic step %0d: got evt=%b done=%b busy=%b rem=%0d, want evt=%b done=%b busy=%b rem=%0d",
                     s, evt_out, done_out, busy_out, remaining_out, e, d, b, r);
         end
      end
   endtask

   task automatic test_period_one();
      period_in = 16'd1; count_in = 8'd5; start_in = 1'b1;
      step();
      start_in = 1'b0;
      for (int s = 1; s <= 6; s++) begin
         step();
         n_checks++;
         if (evt_out !== (s <= 5) || done_out !== (s == 5) || remaining_out !== 8'((s <= 5) ? 5 - s : 0)) begin
            n_fail++;
            $display("FAIL period_one step %0d: got evt=%b done=%b rem=%0d, want evt=%b done=%b rem=%0d",
                     s, evt_out, done_out, remaining_out, s <= 5, s == 5, (s <= 5) ? 5 - s : 0);
         end
      end
   endtask

   task automatic test_zero_count();
      period_in = 16'd7; count_in = 8'd0; start_in = 1'b1;
      step();
      start_in = 1'b0;
      n_checks++;
      if (done_out !== 1'b1 || busy_out !== 1'b0 || evt_out !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_count: got done=%b busy=%b evt=%b, want done=1 busy=0 evt=0", done_out, busy_out, evt_out);
      end
      for (int s = 1; s <= 8; s++) begin
         step();
         n_checks++;
         if (done_out !== 1'b0 || busy_out !== 1'b0 || evt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count quiet %0d: got done=%b busy=%b evt=%b, want 0 0 0", s, done_out, busy_out, evt_out);
         end
      end
   endtask

   // stop lands on the edge where the 3rd event is due
   task automatic test_stop();
      int evts = 0;
      period_in = 16'd4; count_in = 8'd10; start_in = 1'b1;
      step();
      start_in = 1'b0;
      for (int s = 1; s <= 12; s++) begin
         if (s == 12) stop_in = 1'b1;
         step();
         if (evt_out === 1'b1) evts++;
      end
      stop_in = 1'b0;
      n_checks++;
      if (evts !== 2 || busy_out !== 1'b0 || remaining_out !== 8'd0 || done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL stop: got events=%0d busy=%b rem=%0d done=%b, want events=2 busy=0 rem=0 done=0",
                  evts, busy_out, remaining_out, done_out);
      end
      for (int s = 1; s <= 6; s++) begin
         step();
         n_checks++;
         if (evt_out !== 1'b0 || done_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stop quiet %0d: got evt=%b done=%b busy=%b, want 0 0 0", s, evt_out, done_out, busy_out);
         end
      end
   endtask

   task automatic test_async_reset();
      period_in = 16'd5; count_in = 8'd3; start_in = 1'b1;
      step();
      start_in = 1'b0;
      step();
      step();
      #2 rst_in = 1'b1;
      #1;
      n_checks++;
      if ({evt_out, busy_out, done_out, remaining_out} !== 11'd0) begin
         n_fail++;
         $display("FAIL async_reset: got evt=%b busy=%b done=%b rem=%0d, want all 0", evt_out, busy_out, done_out, remaining_out);
      end
      #1 rst_in = 1'b0;
      for (int s = 1; s <= 12; s++) begin
         step();
         n_checks++;
         if (evt_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset quiet %0d: got evt=%b busy=%b, want 0 0", s, evt_out, busy_out);
         end
      end
   endtask

   task automatic test_back_to_back();
      period_in = 16'd2; count_in = 8'd2; start_in = 1'b1;
      step();
      start_in = 1'b0;
      for (int s = 1; s <= 4; s++) step();
      n_checks++;
      if (done_out !== 1'b1 || evt_out !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b first_done: got done=%b evt=%b, want 1 1", done_out, evt_out);
      end
      period_in = 16'd1; count_in = 8'd1; start_in = 1'b1;
      step();
      start_in = 1'b0;
      n_checks++;
      if (busy_out !== 1'b1 || remaining_out !== 8'd1 || done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b accept: got busy=%b rem=%0d done=%b, want 1 1 0", busy_out, remaining_out, done_out);
      end
      step();
      n_checks++;
      if (evt_out !== 1'b1 || done_out !== 1'b1 || remaining_out !== 8'd0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b second_done: got evt=%b done=%b rem=%0d busy=%b, want 1 1 0 0", evt_out, done_out, remaining_out, busy_out);
      end
      step();
   endtask

`ifdef EVT_BURST_GEN_REPEAT_EN
   task automatic test_repeat();
      int evts = 0;
      int dones = 0;
      period_in = 16'd2; count_in = 8'd3; start_in = 1'b1; repeat_in = 1'b1;
      step();
      start_in = 1'b0;
      for (int s = 1; s <= 18; s++) begin
         step();
         if (evt_out === 1'b1) evts++;
         if (done_out === 1'b1) dones++;
         n_checks++;
         if (busy_out !== 1'b1 || evt_out !== (s % 2 == 0) || remaining_out !== 8'(3 - (s / 2) % 3)) begin
            n_fail++;
            $display("FAIL repeat step %0d: got busy=%b evt=%b rem=%0d, want busy=1 evt=%b rem=%0d",
                     s, busy_out, evt_out, remaining_out, s % 2 == 0, 3 - (s / 2) % 3);
         end
      end
      n_checks++;
      if (evts !== 9 || dones !== 3) begin
         n_fail++;
         $display("FAIL repeat totals: got events=%0d dones=%0d, want 9 3", evts, dones);
      end
      stop_in = 1'b1;
      step();
      stop_in = 1'b0; repeat_in = 1'b0;
      n_checks++;
      if (busy_out !== 1'b0 || remaining_out !== 8'd0 || evt_out !== 1'b0) begin
         n_fail++;
         $display("FAIL repeat stop: got busy=%b rem=%0d evt=%b, want 0 0 0", busy_out, remaining_out, evt_out);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_period_one();
      test_zero_count();
      test_stop();
      test_async_reset();
      test_back_to_back();
`ifdef EVT_BURST_GEN_REPEAT_EN
      test_repeat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/evt_burst_gen.md
# evt_burst_gen

Programmable event-strobe generator and the producing end of the single-cycle `evt` interface that our event counters consume. On a start request it emits a burst of `count_in` one-cycle pulses on `evt_out`, spaced `period_in` clock cycles apart. It reports progress through `busy_out`, `remaining_out` and a one-cycle `done_out`. It sits between the control/sequencing logic and the LED timing datapath, for example driving frame ticks, bit ticks or refresh strobes.

## Interface
Parameters:
- `MAX_PERIOD`, 65535: largest accepted spacing in cycles; `PW = $clog2(MAX_PERIOD+1)`.
- `MAX_COUNT`, 255: largest accepted burst length; `CW = $clog2(MAX_COUNT+1)`.

Ports:
- `clk_in` in 1: system clock; everything is on its rising edge.
- `rst_in` in 1: reset, asynchronous and active-high.
- `start_in` in 1: request a burst; sampled only in IDLE.
- `stop_in` in 1: abort the running burst.
- `period_in` in PW: event spacing in cycles; latched at accept.
- `count_in` in CW: number of events; latched at accept.
- `evt_out` out 1: one-cycle event strobe, registered.
- `busy_out` out 1: high while in RUN.
- `done_out` out 1: one-cycle pulse on normal completion.
- `remaining_out` out CW: events still to be emitted.

## Operation
- FSM states: IDLE, RUN.
- Reset (asynchronous, takes effect immediately) forces:
  - state to IDLE;
  - `evt_out`, `busy_out`, `done_out` and `remaining_out` to 0;
  - phase counter to 0.
- IDLE, `start_in`=1, `count_in`≠0 and `period_in`≠0:
  - latch `period_in` and `count_in`;
  - set `remaining_out`=`count_in` and phase=0;
  - go to RUN.
- IDLE, `start_in`=1 with `count_in`=0 or `period_in`=0:
  - stay in IDLE and pulse `done_out` for one cycle;
  - no events are emitted and `busy_out` stays 0.
- RUN, on each edge:
  - if phase = period−1: set phase to 0, assert `evt_out` for one cycle and decrement `remaining_out`;
  - otherwise increment phase.
- Completion: at the edge where the final event is issued (`remaining_out` goes 1→0):
  - `evt_out` and `done_out` are both high in the following cycle;
  - `busy_out` falls on that same edge;
  - state returns to IDLE.
- Abort: `stop_in`=1 in RUN:
  - go to IDLE at the next edge and clear `remaining_out` to 0;
  - no `done_out`;
  - `stop_in` takes priority over an event due on the same edge, so no `evt_out`.
- `stop_in` in IDLE has no effect.
- `start_in` while busy is ignored; it is not queued.
- A new `start_in` is accepted in the first cycle in which `done_out` is high, which gives back-to-back bursts.
- Changes to `period_in`/`count_in` during RUN have no effect.
- Arithmetic: the phase counter is PW bits wide and `remaining_out` is CW bits wide. Neither can wrap because of the decode conditions above. Inputs above MAX_* are outside the contract.

## Timing
- Start is accepted at edge E0. The k-th `evt_out` is high in the cycle after edge E0 + k·period, for k = 1..count.
- Latency from accept to the first event is `period` cycles. With period=1, events occur on consecutive cycles.
- `busy_out` is high in the cycle after E0 through the cycle before the last `evt_out`.
- `remaining_out` updates on the same edge that raises `evt_out`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `EVT_BURST_GEN_REPEAT_EN` defined:
  - adds input port `repeat_in` (1 bit);
  - if `repeat_in`=1 at the completion edge, the generator reloads the latched count, keeps the latched period, resets phase to 0 and stays in RUN;
  - `done_out` still pulses once per burst, and `busy_out` stays high;
  - `stop_in` is the only way to exit.
- Not defined: the port is absent and every burst ends in IDLE.

## Structure
- Shared package `evt_pkg` holds:
  - `typedef enum logic {EVT_IDLE, EVT_RUN} evt_gen_state_t`;
  - the width helper functions for PW/CW.
- One sub-module, `evt_period_timer`. It owns the phase counter:
  - inputs: clear, enable, period;
  - output: single-cycle `tick` when phase = period−1.
- The top level holds the FSM, the `remaining` counter and the output registers.

## Test plan
- period=3, count=4: `evt_out` at E0+3, +6, +9, +12; `remaining_out` 4→3→2→1→0; `done_out` high with the 4th event; `busy_out` low afterwards.
- period=1, count=5: `evt_out` high for exactly 5 consecutive cycles; `done_out` coincides with the 5th event.
- count=0, period=7: `done_out` pulses one cycle after accept; no `evt_out`; `busy_out` never rises.
- period=4, count=10, `stop_in` asserted on the edge where the 3rd event is due:
  - exactly 2 events seen, 3rd suppressed;
  - IDLE next cycle, `remaining_out`=0, no `done_out`.
- `rst_in` asserted mid-burst between clock edges: all outputs read 0 before the next edge; no events after release until a new `start_in`.
- With `EVT_BURST_GEN_REPEAT_EN`, period=2, count=3, `repeat_in`=1: 9 evenly spaced events over three bursts, 3 `done_out` pulses, `busy_out` continuously high; `stop_in` ends it.
